write_back_pipe: RTL and testbench
==================================

Name: write_back_pipe

Overview:
- Parametrised next-generation write-back stage for the RISC-V pipeline.
- Selects the write-back value (ALU result, load data, or link address pc+4). Sign- or zero-extends sub-word loads.
- Carries the result through a configurable number of register stages with valid, stall and flush control.
- Provides a combinational bypass lookup for hazard forwarding and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_W, 5, register-index width.
- PIPE_DEPTH, 2, number of register stages from input to output; legal range 1..4.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input bundle is valid this cycle.
- stall  in  1  hold all stages.
- flush  in  1  kill all in-flight entries.
- wb_type  in  2  00 none, 01 normal (exe_result), 10 load, 11 jal/jalr (pc+4).
- load_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- byte_off  in  log2(XLEN/8)  low address bits of the load.
- pc  in  XLEN  instruction PC.
- mem_rdata  in  XLEN  raw aligned memory word.
- exe_result  in  XLEN  ALU/shifter result.
- rd_in  in  REG_W  destination register.
- fwd_rd  in  REG_W  register index queried for bypass.
- out_valid  out  1  output bundle is valid.
- wb_en  out  1  register-file write enable.
- wb_value  out  XLEN  value to write.
- wb_rd  out  REG_W  destination register.
- fwd_hit  out  1  fwd_rd matches an in-flight write.
- fwd_value  out  XLEN  youngest matching value.
- retired  out  CNT_W  count of valid entries reaching the output.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all stage valids, out_valid, wb_en, wb_value, wb_rd and retired clear to 0. Reset overrides stall and flush. Reset mid-operation discards all entries.
- Stage 1 captures the selected value, rd_in, and valid = in_valid & (wb_type != 00).
- wb_type 00 with in_valid=1 is retired silently: it is not counted and produces no out_valid.
- Each later stage copies the previous one. The last stage drives the out_* ports directly.
- Latency: an input accepted at edge N appears on the outputs after edge N+PIPE_DEPTH-1, i.e. registered PIPE_DEPTH cycles after presentation.
- wb_en = out_valid & (wb_rd != 0). Writes to x0 still assert out_valid and are counted, but never enable the write.
- stall=1: every stage and all outputs hold. in_valid is ignored, and upstream must hold its bundle. The retire counter does not increment.
- flush=1: all stage valids and out_valid clear next edge. The input presented that cycle is dropped. Data fields may retain stale values.
- flush and stall both asserted: flush wins.
- Link value: pc+4, truncated to XLEN; it wraps modulo 2^XLEN.
- Load extraction, byte lane = byte_off:
  - LB/LBU take byte[byte_off]; LH/LHU take halfword[byte_off>>1]; LW/LWU take word[byte_off>>2] (XLEN=64); LD takes the full word.
  - Signed forms sign-extend to XLEN; unsigned forms zero-extend.
  - 011/110 with XLEN=32, and the reserved code 111, behave as LW with byte_off ignored.
  - Misaligned low offset bits within a half/word are ignored.
- Forwarding (combinational):
  - Scans every valid stage, including the output stage, for rd == fwd_rd with rd != 0.
  - The youngest stage (closest to the input) wins.
  - No match, or fwd_rd=0: fwd_hit=0 and fwd_value=0.
- Retired counter: +1 on every edge where a valid entry moves into the output stage (not stalled, not flushed). It wraps at 2^CNT_W.

Test Plan:
- PIPE_DEPTH=2: in_valid=1, wb_type=01, exe_result=0x1234_5678, rd=5 -> after 2 edges: out_valid=1, wb_en=1, wb_value=0x1234_5678, wb_rd=5, retired=1.
- Load: mem_rdata=0x80FF_7F01, LB off=3 -> 0xFFFF_FF80; LBU off=3 -> 0x0000_0080; LH off=2 -> 0xFFFF_80FF; LHU off=0 -> 0x0000_7F01.
- JAL: pc=0xFFFF_FFFC, wb_type=11, rd=1 -> wb_value=0x0000_0000. Same with rd=0 -> out_valid=1, wb_en=0, retired increments.
- Stall for 3 cycles mid-stream -> outputs frozen and retired unchanged; release -> sequence resumes with no loss or duplication. Flush+stall together -> all valids 0 next edge.
- Back-to-back writes to rd=7 with values 0xA then 0xB in stages 2 and 1; fwd_rd=7 -> fwd_hit=1, fwd_value=0xB. fwd_rd=0 -> fwd_hit=0.
- rst_n=0 while stages are full -> next edge all outputs 0, retired=0. XLEN=64 LWU off=4 on 0x8000_0001_0000_0002 -> 0x0000_0000_8000_0001.

Source files
------------

// File: rtl/write_back_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : write_back_pipe_if
// Description : Bundle interface for the write-back stage. Carries the
//               instruction bundle in, the register-file write out, the
//               bypass query/response and the retire count.
// Revision    : 1.0 - initial release
// ============================================================================
interface write_back_pipe_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  localparam int OFF_W = $clog2(XLEN / 8);

  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [1:0]       wb_type;
  logic [2:0]       load_funct3;
  logic [OFF_W-1:0] byte_off;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  mem_rdata;
  logic [XLEN-1:0]  exe_result;
  logic [REG_W-1:0] rd_in;
  logic [REG_W-1:0] fwd_rd;

  logic             out_valid;
  logic             wb_en;
  logic [XLEN-1:0]  wb_value;
  logic [REG_W-1:0] wb_rd;
  logic             fwd_hit;
  logic [XLEN-1:0]  fwd_value;
  logic [CNT_W-1:0] retired;

  // Upstream side: drives the bundle and bypass query, observes results.
  modport master (
    output in_valid, stall, flush, wb_type, load_funct3, byte_off,
           pc, mem_rdata, exe_result, rd_in, fwd_rd,
    input  out_valid, wb_en, wb_value, wb_rd, fwd_hit, fwd_value, retired
  );

  // Write-back stage side.
  modport slave (
    input  in_valid, stall, flush, wb_type, load_funct3, byte_off,
           pc, mem_rdata, exe_result, rd_in, fwd_rd,
    output out_valid, wb_en, wb_value, wb_rd, fwd_hit, fwd_value, retired
  );
endinterface
`default_nettype wire

// File: rtl/write_back_pipe.sv
`default_nettype none
// ============================================================================
// Module      : write_back_pipe
// Description : RISC-V write-back stage. Selects ALU / load / link value,
//               extracts and extends sub-word loads, carries the result
//               through PIPE_DEPTH register stages with stall and flush,
//               offers a combinational bypass lookup and counts retirements.
// Revision    : 1.0 - initial release
// ============================================================================
module write_back_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_W      = 5,
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input wire               clk,
  input wire               rst_n,
  write_back_pipe_if.slave bus
);
  localparam int         OFF_W   = $clog2(XLEN / 8);
  localparam int         LAST    = PIPE_DEPTH - 1;
  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b10;
  localparam logic [1:0] WB_LINK = 2'b11;

  logic [OFF_W-1:0] off_half;
  logic [OFF_W-1:0] off_word;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      lane_w;
  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  sel_val;
  logic             in_take;
  logic             enter_out;

  logic [PIPE_DEPTH-1:0] valid_q;
  logic [XLEN-1:0]       value_q [PIPE_DEPTH];
  logic [REG_W-1:0]      rd_q    [PIPE_DEPTH];
  logic [CNT_W-1:0]      retired_q;
  logic [CNT_W-1:0]      retired_d;

  // Load lane extraction; low offset bits below the access size are dropped
  // so misaligned halves/words read the naturally aligned container.
  always_comb begin
    off_half = bus.byte_off & ~OFF_W'(1);
    off_word = (XLEN == 64) ? (bus.byte_off & ~OFF_W'(3)) : '0;
    lane_b   = 8'(bus.mem_rdata >> {bus.byte_off, 3'b000});
    lane_h   = 16'(bus.mem_rdata >> {off_half, 3'b000});
    lane_w   = 32'(bus.mem_rdata >> {off_word, 3'b000});
    case (bus.load_funct3)
      3'b000:  load_val = XLEN'($signed(lane_b));
      3'b100:  load_val = XLEN'(lane_b);
      3'b001:  load_val = XLEN'($signed(lane_h));
      3'b101:  load_val = XLEN'(lane_h);
      3'b010:  load_val = XLEN'($signed(lane_w));
      // LD on RV32 degrades to a full-word LW, which is the raw word.
      3'b011:  load_val = (XLEN == 64) ? bus.mem_rdata
                                       : XLEN'($signed(bus.mem_rdata[31:0]));
      3'b110:  load_val = (XLEN == 64) ? XLEN'(lane_w)
                                       : XLEN'($signed(bus.mem_rdata[31:0]));
      // Reserved code: LW from the bottom word, offset ignored.
      default: load_val = XLEN'($signed(bus.mem_rdata[31:0]));
    endcase
  end

  // Write-back source select; the link value wraps naturally at XLEN bits.
  always_comb begin
    case (bus.wb_type)
      WB_LOAD: sel_val = load_val;
      WB_LINK: sel_val = bus.pc + XLEN'(4);
      default: sel_val = bus.exe_result;
    endcase
  end

  // wb_type 00 is retired silently, so it never becomes a valid entry.
  assign in_take = bus.in_valid & (bus.wb_type != WB_NONE);

  // Stage registers: reset beats flush beats stall; flush keeps stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        value_q[i] <= '0;
        rd_q[i]    <= '0;
      end
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (!bus.stall) begin
      valid_q[0] <= in_take;
      value_q[0] <= sel_val;
      rd_q[0]    <= bus.rd_in;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        value_q[i] <= value_q[i-1];
        rd_q[i]    <= rd_q[i-1];
      end
    end
  end

  // Entry about to land in the output stage: the input itself when the pipe
  // is one deep, otherwise the stage just before the last.
  if (PIPE_DEPTH == 1) begin : g_single_stage
    assign enter_out = in_take;
  end else begin : g_multi_stage
    assign enter_out = valid_q[PIPE_DEPTH-2];
  end

  // Retire counter next state: counts only real advances into the output.
  always_comb begin
    retired_d = retired_q;
    if (!bus.flush && !bus.stall && enter_out) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Retire counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  // Bypass lookup: scan oldest to youngest so the youngest match wins.
  always_comb begin
    bus.fwd_hit   = 1'b0;
    bus.fwd_value = '0;
    for (int i = LAST; i >= 0; i--) begin
      if (valid_q[i] && (rd_q[i] == bus.fwd_rd) && (bus.fwd_rd != '0)) begin
        bus.fwd_hit   = 1'b1;
        bus.fwd_value = value_q[i];
      end
    end
  end

  assign bus.out_valid = valid_q[LAST];
  assign bus.wb_value  = value_q[LAST];
  assign bus.wb_rd     = rd_q[LAST];
  assign bus.wb_en     = valid_q[LAST] & (rd_q[LAST] != '0);
  assign bus.retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_write_back_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_back_pipe
// Description : Scoreboard bench for write_back_pipe. A 32-bit, two-deep
//               instance is checked every cycle against a queue of expected
//               entries; a 64-bit, one-deep instance covers wide loads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_back_pipe;
  localparam int PIPE_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  write_back_pipe_if #(.XLEN(32), .REG_W(5), .CNT_W(32)) bus ();
  write_back_pipe_if #(.XLEN(64), .REG_W(5), .CNT_W(32)) bus64 ();

  write_back_pipe #(.XLEN(32), .REG_W(5), .PIPE_DEPTH(PIPE_DEPTH), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  write_back_pipe #(.XLEN(64), .REG_W(5), .PIPE_DEPTH(1), .CNT_W(32)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference for the 32-bit write-back value.
  function automatic logic [31:0] ref_wb(input logic [1:0] t, input logic [2:0] f3,
                                         input logic [1:0] off, input logic [31:0] pc,
                                         input logic [31:0] rdata, input logic [31:0] exe);
    int          o;
    logic [7:0]  b;
    logic [15:0] h;
    o = int'(off);
    b = rdata[o*8 +: 8];
    h = rdata[(o/2)*16 +: 16];
    if (t == 2'b11) return pc + 32'd4;
    if (t != 2'b10) return exe;
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

  // Scoreboard: entries pushed as stimulus is accepted, aged on each
  // advancing edge, popped once they leave the output stage.
  typedef struct {
    logic [31:0] val;
    logic [4:0]  rd;
    int          age;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] cur_exp;
  int unsigned ret_m  = 0;
  bit          mon_on = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      sb.delete();
      ret_m = 0;
    end else if (bus.flush) begin
      sb.delete();
    end else if (!bus.stall) begin
      if (sb.size() > 0 && sb[0].age == PIPE_DEPTH - 1) void'(sb.pop_front());
      for (int i = 0; i < sb.size(); i++) sb[i].age = sb[i].age + 1;
      if (bus.in_valid && bus.wb_type != 2'b00) sb.push_back('{cur_exp, bus.rd_in, 0});
      if (sb.size() > 0 && sb[0].age == PIPE_DEPTH - 1) ret_m++;
    end
  end

  always @(negedge clk) begin
    logic exp_v;
    if (mon_on) begin
      exp_v = (sb.size() > 0) && (sb[0].age == PIPE_DEPTH - 1);
      check("mon_out_valid", 64'(bus.out_valid), 64'(exp_v));
      if (exp_v) begin
        check("mon_wb_value", 64'(bus.wb_value), 64'(sb[0].val));
        check("mon_wb_rd", 64'(bus.wb_rd), 64'(sb[0].rd));
        check("mon_wb_en", 64'(bus.wb_en), 64'(sb[0].rd != 5'd0));
      end
      check("mon_retired", 64'(bus.retired), 64'(ret_m));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic put(input logic [1:0] t, input logic [2:0] f3, input logic [1:0] off,
                     input logic [31:0] pc, input logic [31:0] rdata, input logic [31:0] exe,
                     input logic [4:0] rd, input logic [31:0] exp);
    bus.in_valid    = 1'b1;
    bus.wb_type     = t;
    bus.load_funct3 = f3;
    bus.byte_off    = off;
    bus.pc          = pc;
    bus.mem_rdata   = rdata;
    bus.exe_result  = exe;
    bus.rd_in       = rd;
    cur_exp         = exp;
  endtask

  task automatic put_ref(input logic [1:0] t, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] pc, input logic [31:0] rdata, input logic [31:0] exe,
                         input logic [4:0] rd);
    put(t, f3, off, pc, rdata, exe, rd, ref_wb(t, f3, off, pc, rdata, exe));
  endtask

  // 64-bit load table: funct3, offset, expected value (all on one word).
  localparam logic [63:0] RD64 = 64'h8000_0001_0000_0002;
  logic [2:0]  t64_f3  [6] = '{3'b110, 3'b010, 3'b011, 3'b000, 3'b101, 3'b111};
  logic [2:0]  t64_off [6] = '{3'd4, 3'd4, 3'd5, 3'd7, 3'd6, 3'd4};
  logic [63:0] t64_exp [6] = '{64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001,
                               64'h8000_0001_0000_0002, 64'hFFFF_FFFF_FFFF_FF80,
                               64'h0000_0000_0000_8000, 64'h0000_0000_0000_0002};

  initial begin
    logic prev_stall;
    rst_n = 1'b0;
    idle();
    put(2'b00, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    bus.in_valid = 1'b0;
    bus.fwd_rd   = 5'd5;
    cur_exp      = '0;
    bus64.in_valid = 1'b0; bus64.stall = 1'b0; bus64.flush = 1'b0;
    bus64.wb_type = 2'b10; bus64.load_funct3 = 3'b000; bus64.byte_off = 3'd0;
    bus64.pc = '0; bus64.mem_rdata = RD64; bus64.exe_result = '0;
    bus64.rd_in = 5'd3; bus64.fwd_rd = 5'd0;

    // Reset state.
    tick();
    mon_on = 1'b1;
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_wb_en", 64'(bus.wb_en), 64'd0);
    check("rst_wb_value", 64'(bus.wb_value), 64'd0);
    check("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    check("rst_retired", 64'(bus.retired), 64'd0);
    check("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
    rst_n = 1'b1;

    // Basic ALU write: two-edge latency.
    put(2'b01, 3'b000, 2'd0, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 32'h1234_5678);
    tick();
    idle();
    check("t1_early_valid", 64'(bus.out_valid), 64'd0);
    tick();
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_wb_en", 64'(bus.wb_en), 64'd1);
    check("t1_wb_value", 64'(bus.wb_value), 64'h1234_5678);
    check("t1_wb_rd", 64'(bus.wb_rd), 64'd5);
    check("t1_retired", 64'(bus.retired), 64'd1);
    tick();

    // Loads, back to back; the scoreboard compares each on output.
    put(2'b10, 3'b000, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0, 5'd10, 32'hFFFF_FF80); tick();
    put(2'b10, 3'b100, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0, 5'd11, 32'h0000_0080); tick();
    put(2'b10, 3'b001, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0, 5'd12, 32'hFFFF_80FF); tick();
    put(2'b10, 3'b101, 2'd0, 32'h0, 32'h80FF_7F01, 32'h0, 5'd13, 32'h0000_7F01); tick();
    put(2'b10, 3'b001, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0, 5'd14, 32'hFFFF_80FF); tick();
    put(2'b10, 3'b010, 2'd2, 32'h0, 32'h80FF_7F01, 32'h0, 5'd15, 32'h80FF_7F01); tick();
    put(2'b10, 3'b011, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 5'd16, 32'h80FF_7F01); tick();
    put(2'b10, 3'b110, 2'd3, 32'h0, 32'h80FF_7F01, 32'h0, 5'd17, 32'h80FF_7F01); tick();
    put(2'b10, 3'b111, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 5'd18, 32'h80FF_7F01); tick();

    // Link value wraps; rd=0 still retires but never writes.
    put(2'b11, 3'b000, 2'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd1, 32'h0); tick();
    put(2'b11, 3'b000, 2'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd0, 32'h0); tick();
    idle();
    tick();
    check("x0_out_valid", 64'(bus.out_valid), 64'd1);
    check("x0_wb_en", 64'(bus.wb_en), 64'd0);
    check("x0_wb_value", 64'(bus.wb_value), 64'd0);

    // wb_type 00 is dropped silently.
    put(2'b00, 3'b000, 2'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd9, 32'h0);
    tick();
    idle();
    tick();
    tick();
    check("none_silent", 64'(bus.out_valid), 64'd0);

    // Stream with a three-cycle stall in the middle.
    for (int k = 0; k < 10; k++) begin
      if (k >= 3 && k < 6) begin
        bus.stall = 1'b1;
      end else begin
        bus.stall = 1'b0;
        put_ref(2'b01, 3'b000, 2'd0, 32'h0, 32'h0, $urandom, 5'($urandom_range(1, 31)));
      end
      tick();
    end
    idle();
    tick(); tick(); tick();

    // Forwarding: stage 1 holds 0xA, stage 0 holds 0xB, both to x7.
    put(2'b01, 3'b000, 2'd0, 32'h0, 32'h0, 32'hA, 5'd7, 32'hA); tick();
    put(2'b01, 3'b000, 2'd0, 32'h0, 32'h0, 32'hB, 5'd7, 32'hB); tick();
    bus.in_valid = 1'b0;
    bus.stall    = 1'b1;
    bus.fwd_rd   = 5'd7; #1;
    check("fwd_hit_young", 64'(bus.fwd_hit), 64'd1);
    check("fwd_val_young", 64'(bus.fwd_value), 64'hB);
    bus.fwd_rd = 5'd0; #1;
    check("fwd_x0_hit", 64'(bus.fwd_hit), 64'd0);
    check("fwd_x0_val", 64'(bus.fwd_value), 64'd0);
    bus.fwd_rd = 5'd9; #1;
    check("fwd_miss_hit", 64'(bus.fwd_hit), 64'd0);
    tick();
    idle();
    tick();
    bus.fwd_rd = 5'd7; #1;
    check("fwd_out_stage_hit", 64'(bus.fwd_hit), 64'd1);
    check("fwd_out_stage_val", 64'(bus.fwd_value), 64'hB);
    tick();

    // Flush together with stall clears everything, input dropped.
    put_ref(2'b01, 3'b000, 2'd0, 32'h0, 32'h0, 32'h111, 5'd20); tick();
    put_ref(2'b01, 3'b000, 2'd0, 32'h0, 32'h0, 32'h222, 5'd21); tick();
    put_ref(2'b01, 3'b000, 2'd0, 32'h0, 32'h0, 32'h333, 5'd22);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    idle();
    bus.fwd_rd = 5'd21; #1;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_fwd_hit", 64'(bus.fwd_hit), 64'd0);
    tick(); tick();
    check("flush_no_leak", 64'(bus.out_valid), 64'd0);

    // Reset while both stages are occupied.
    put_ref(2'b01, 3'b000, 2'd0, 32'h0, 32'h0, 32'h444, 5'd23); tick();
    put_ref(2'b01, 3'b000, 2'd0, 32'h0, 32'h0, 32'h555, 5'd24); tick();
    idle();
    rst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_wb_en", 64'(bus.wb_en), 64'd0);
    check("mid_rst_wb_value", 64'(bus.wb_value), 64'd0);
    check("mid_rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    check("mid_rst_retired", 64'(bus.retired), 64'd0);
    rst_n = 1'b1;

    // Random traffic with occasional stall and flush.
    prev_stall = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!prev_stall) begin
        put_ref(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.stall  = ($urandom_range(0, 4) == 0);
      bus.flush  = ($urandom_range(0, 11) == 0);
      prev_stall = bus.stall && !bus.flush;
      tick();
    end
    idle();
    tick(); tick(); tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    // 64-bit instance, one stage deep: result visible right after the edge.
    for (int k = 0; k < 6; k++) begin
      bus64.in_valid    = 1'b1;
      bus64.load_funct3 = t64_f3[k];
      bus64.byte_off    = t64_off[k];
      tick();
      check($sformatf("x64_value_%0d", k), bus64.wb_value, t64_exp[k]);
      check($sformatf("x64_valid_%0d", k), 64'(bus64.out_valid), 64'd1);
    end
    bus64.in_valid = 1'b0;
    tick();
    check("x64_retired", 64'(bus64.retired), 64'd6);
    check("x64_idle_valid", 64'(bus64.out_valid), 64'd0);

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
